text_cursor_writer: RTL and testbench



---
 rtl/text_pkg.sv | 18 +
 rtl/text_addr_calc.sv | 32 +++
 rtl/text_cursor_writer.sv | 143 ++++++++++++++
 tb/tb_text_cursor_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared types and ASCII codes for the text-mode cursor writer.
// Pure declarations: no latency, no flow control of its own.
package text_pkg;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    LINE_CLEAR
  } state_t;

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

endpackage

// File: rtl/text_addr_calc.sv
// Maps (top_row, logical row, col) to a linear character RAM address.
// Purely combinational, zero latency, no backpressure; wraps the row without a divider.
module text_addr_calc #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic [ROW_W-1:0]  top_row,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  localparam int SUM_W = ROW_W + 1;

  logic [SUM_W-1:0] sum;
  logic [ROW_W-1:0] phys_row;

  always_comb begin
    sum = {1'b0, top_row} + {1'b0, row};
    // Both operands are < ROWS, so one conditional subtract is a full modulo.
    if (sum >= SUM_W'(ROWS)) begin
      phys_row = ROW_W'(sum - SUM_W'(ROWS));
    end else begin
      phys_row = sum[ROW_W-1:0];
    end
    addr = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col);
  end

endmodule

// File: rtl/text_cursor_writer.sv
// Turns ASCII keystrokes into character RAM writes with cursor, wrap and circular scroll.
// Writes appear one cycle after acceptance; in_ready is low while the screen or a scrolled-in line is being cleared.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic                     mainclk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_ascii,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  top_row
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS-1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS*COLS-1);

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row_nxt, top_nxt, calc_row;
  logic [COL_W-1:0]  col_nxt, calc_col, clr_col, clr_col_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt, calc_addr, wr_addr_nxt;
  logic              wr_en_nxt, newline;
  logic [7:0]        wr_data_nxt;

  // In LINE_CLEAR the cursor sits on the last row and top_row has already
  // advanced, so (top_row, cursor_row) lands on the old top physical row.
  text_addr_calc #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .top_row (top_row),
    .row     (calc_row),
    .col     (calc_col),
    .addr    (calc_addr)
  );

  assign in_ready    = (state == IDLE);
  assign wr_addr_nxt = (state == INIT_CLEAR) ? clr_cnt : calc_addr;

  always_comb begin
    state_nxt   = state;
    row_nxt     = cursor_row;
    col_nxt     = cursor_col;
    top_nxt     = top_row;
    clr_cnt_nxt = clr_cnt;
    clr_col_nxt = clr_col;
    wr_en_nxt   = 1'b0;
    wr_data_nxt = SPACE;
    calc_row    = cursor_row;
    calc_col    = cursor_col;
    newline     = 1'b0;
    case (state)
      INIT_CLEAR: begin
        wr_en_nxt   = 1'b1;
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_CELL) state_nxt = IDLE;
      end
      LINE_CLEAR: begin
        wr_en_nxt   = 1'b1;
        calc_col    = clr_col;
        clr_col_nxt = clr_col + COL_W'(1);
        if (clr_col == LAST_COL) state_nxt = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          if (in_ascii >= PRINT_LO && in_ascii <= PRINT_HI) begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = in_ascii;
            if (cursor_col < LAST_COL) begin
              col_nxt = cursor_col + COL_W'(1);
            end else begin
              col_nxt = '0;
              newline = 1'b1;
            end
          end else if (in_ascii == CR || in_ascii == LF) begin
            col_nxt = '0;
            newline = 1'b1;
          end else if (in_ascii == BS) begin
            // Backspace erases at the destination, never past the home position.
            if (cursor_col != '0) begin
              col_nxt   = cursor_col - COL_W'(1);
              calc_col  = cursor_col - COL_W'(1);
              wr_en_nxt = 1'b1;
            end else if (cursor_row != '0) begin
              row_nxt   = cursor_row - ROW_W'(1);
              col_nxt   = LAST_COL;
              calc_row  = cursor_row - ROW_W'(1);
              calc_col  = LAST_COL;
              wr_en_nxt = 1'b1;
            end
          end
          if (newline) begin
            if (cursor_row < LAST_ROW) begin
              row_nxt = cursor_row + ROW_W'(1);
            end else begin
              top_nxt     = (top_row == LAST_ROW) ? '0 : top_row + ROW_W'(1);
              clr_col_nxt = '0;
              state_nxt   = LINE_CLEAR;
            end
          end
        end
      end
      default: state_nxt = INIT_CLEAR;
    endcase
  end

  always_ff @(posedge mainclk) begin
    if (reset) begin
      state      <= INIT_CLEAR;
      cursor_row <= '0;
      cursor_col <= '0;
      top_row    <= '0;
      clr_cnt    <= '0;
      clr_col    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      cursor_row <= row_nxt;
      cursor_col <= col_nxt;
      top_row    <= top_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clr_col    <= clr_col_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Randomised and directed bench for text_cursor_writer against a screen-level model.
module tb_text_cursor_writer;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = $clog2(COLS*ROWS);
  localparam int NCELL  = COLS*ROWS;

  logic              mainclk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_ascii = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [4:0]        cursor_row;
  logic [6:0]        cursor_col;
  logic [4:0]        top_row;

  int checks = 0;
  int errors = 0;
  int obs_addr[$], obs_dat[$], exp_addr[$], exp_dat[$];
  int m_row, m_col, m_top;

  text_cursor_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .mainclk    (mainclk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ascii   (in_ascii),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .top_row    (top_row)
  );

  always #5 mainclk = ~mainclk;

  // Log every RAM write just after the edge that produced it.
  always @(posedge mainclk) begin
    #1;
    if (wr_en === 1'b1) begin
      obs_addr.push_back(int'(wr_addr));
      obs_dat.push_back(int'(wr_data));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge mainclk);
    #2;
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_dat.delete();
    exp_addr.delete(); exp_dat.delete();
  endtask

  // Screen model: physical row of a logical line is (top + row) mod ROWS.
  task automatic model_put(input int row, input int col, input int ch);
    exp_addr.push_back(((m_top + row) % ROWS) * COLS + col);
    exp_dat.push_back(ch);
  endtask

  task automatic model_key(input logic [7:0] k);
    bit nl = 0;
    int old_top;
    if (k >= 8'h20 && k <= 8'h7E) begin
      model_put(m_row, m_col, int'(k));
      if (m_col < COLS-1) m_col++;
      else begin m_col = 0; nl = 1; end
    end else if (k == 8'h0D || k == 8'h0A) begin
      m_col = 0; nl = 1;
    end else if (k == 8'h08) begin
      if (m_col > 0) begin m_col--; model_put(m_row, m_col, 32); end
      else if (m_row > 0) begin m_row--; m_col = COLS-1; model_put(m_row, m_col, 32); end
    end
    if (nl) begin
      if (m_row < ROWS-1) m_row++;
      else begin
        old_top = m_top;
        m_top = (m_top + 1) % ROWS;
        for (int c = 0; c < COLS; c++) begin
          exp_addr.push_back(old_top * COLS + c);
          exp_dat.push_back(32);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] k);
    int n = 0;
    in_valid = 1'b1;
    in_ascii = k;
    while (in_ready !== 1'b1 && n < 3000) begin step(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1 (key %h)", in_ready, n, k);
    end
    step();
    in_valid = 1'b0;
    in_ascii = 8'($urandom);
    model_key(k);
  endtask

  task automatic test_reset();
    int cycles = 0, bad = 0, early = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    step(); step();
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0 || top_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: wr_en=%b in_ready=%b row=%0d col=%0d top=%0d, required all 0",
               wr_en, in_ready, cursor_row, cursor_col, top_row);
    end
    m_row = 0; m_col = 0; m_top = 0;
    clear_logs();
    reset = 1'b0;
    while (obs_addr.size() < NCELL && cycles < NCELL + 200) begin
      if (in_ready !== 1'b0) early++;
      step();
      cycles++;
    end
    checks++;
    if (obs_addr.size() != NCELL || cycles != NCELL) begin
      errors++;
      $display("FAIL init_count: %0d writes in %0d cycles, required %0d in %0d", obs_addr.size(), cycles, NCELL, NCELL);
    end
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] != i || obs_dat[i] != 32) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_content: %0d writes not (addr=i, data=20), required 0", bad);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL init_ready_early: in_ready high in %0d clear cycles, required 0", early);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || obs_addr.size() != NCELL) begin
      errors++;
      $display("FAIL init_ready: in_ready=%b writes=%0d, required 1 and %0d", in_ready, obs_addr.size(), NCELL);
    end
  endtask

  task automatic test_print_bs();
    clear_logs();
    send(8'h41);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[$] != 0 || obs_dat[$] != 'h41 || cursor_row !== 5'd0 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL print_A: writes=%0d addr=%0d data=%h cur=(%0d,%0d), required 1, 0, 41, (0,1)",
               obs_addr.size(), obs_addr[$], obs_dat[$], cursor_row, cursor_col);
    end
    send(8'h08);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[$] != 0 || obs_dat[$] != 'h20 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL bs_erase: writes=%0d addr=%0d data=%h col=%0d, required 2, 0, 20, 0",
               obs_addr.size(), obs_addr[$], obs_dat[$], cursor_col);
    end
    send(8'h08);
    step(); step();
    checks++;
    if (obs_addr.size() != 2 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL bs_home: writes=%0d cur=(%0d,%0d), required 2 and (0,0)", obs_addr.size(), cursor_row, cursor_col);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    for (int i = 0; i < COLS; i++) send(8'h78);
    checks++;
    if (obs_addr.size() != COLS || obs_addr[$] != 69 || obs_dat[$] != 'h78 || cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL wrap: writes=%0d last=%0d/%h cur=(%0d,%0d), required 70, 69/78, (1,0)",
               obs_addr.size(), obs_addr[$], obs_dat[$], cursor_row, cursor_col);
    end
    send(8'h08);
    checks++;
    if (obs_addr[$] != 69 || obs_dat[$] != 'h20 || cursor_row !== 5'd0 || cursor_col !== 7'd69) begin
      errors++;
      $display("FAIL bs_unwrap: last=%0d/%h cur=(%0d,%0d), required 69/20, (0,69)",
               obs_addr[$], obs_dat[$], cursor_row, cursor_col);
    end
  endtask

  task automatic test_scroll();
    int n = 0, bad = 0;
    while (m_row < ROWS-1) send(8'h0D);
    clear_logs();
    send(8'h0D);
    while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != COLS || top_row !== 5'd1 || cursor_row !== 5'd29) begin
      errors++;
      $display("FAIL scroll_busy: busy=%0d top=%0d row=%0d, required 70, 1, 29", n, top_row, cursor_row);
    end
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] != i || obs_dat[i] != 32) bad++;
    checks++;
    if (obs_addr.size() != COLS || bad != 0) begin
      errors++;
      $display("FAIL scroll_clear: writes=%0d bad=%0d, required 70 and 0", obs_addr.size(), bad);
    end
    send(8'h42);
    checks++;
    if (obs_addr[$] != 0 || obs_dat[$] != 'h42 || cursor_row !== 5'd29 || cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL scroll_B: addr=%0d data=%h cur=(%0d,%0d), required 0, 42, (29,1)",
               obs_addr[$], obs_dat[$], cursor_row, cursor_col);
    end
  endtask

  task automatic test_hold_in_clear();
    int bad = 0, ncs = 0;
    clear_logs();
    send(8'h0D);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_busy: in_ready=%b during line clear, required 0", in_ready);
    end
    send(8'h43);
    step(); step(); step();
    for (int i = 0; i < obs_addr.size() && i < COLS; i++)
      if (obs_addr[i] != COLS + i || obs_dat[i] != 32) bad++;
    foreach (obs_dat[i]) if (obs_dat[i] == 'h43) ncs++;
    checks++;
    if (obs_addr.size() != COLS + 1 || bad != 0 || ncs != 1 || obs_addr[$] != 70 || obs_dat[$] != 'h43) begin
      errors++;
      $display("FAIL hold_C: writes=%0d bad_clear=%0d C_writes=%0d last=%0d/%h, required 71, 0, 1, 70/43",
               obs_addr.size(), bad, ncs, obs_addr[$], obs_dat[$]);
    end
  endtask

  task automatic test_discard();
    logic [7:0] junk [6] = '{8'h00, 8'h90, 8'h7F, 8'hFF, 8'h01, 8'h1B};
    logic [4:0] r0, t0;
    logic [6:0] c0;
    r0 = cursor_row; c0 = cursor_col; t0 = top_row;
    clear_logs();
    foreach (junk[i]) send(junk[i]);
    step(); step();
    checks++;
    if (obs_addr.size() != 0 || cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col) || top_row !== 5'(m_top)
        || cursor_row !== r0 || cursor_col !== c0 || top_row !== t0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL discard: writes=%0d cur=(%0d,%0d) top=%0d rdy=%b, required 0, (%0d,%0d), %0d, 1",
               obs_addr.size(), cursor_row, cursor_col, top_row, in_ready, r0, c0, t0);
    end
  endtask

  task automatic test_random();
    int n = 0, bad = 0, r;
    logic [7:0] k;
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      k = 8'($urandom_range(32, 126));
      else if (r < 76) k = 8'h0D;
      else if (r < 80) k = 8'h0A;
      else if (r < 92) k = 8'h08;
      else             k = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
      send(k);
      checks++;
      if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col) || top_row !== 5'(m_top)) begin
        errors++;
        $display("FAIL rand_cursor: key %h gave (%0d,%0d) top=%0d, required (%0d,%0d) top=%0d",
                 k, cursor_row, cursor_col, top_row, m_row, m_col, m_top);
      end
    end
    while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
    step(); step();
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      if (obs_addr[i] != exp_addr[i] || obs_dat[i] != exp_dat[i]) bad++;
    checks++;
    if (obs_addr.size() != exp_addr.size() || bad != 0) begin
      errors++;
      $display("FAIL rand_writes: %0d writes with %0d differing, required %0d writes and 0",
               obs_addr.size(), bad, exp_addr.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    while (m_row < ROWS-1) send(8'h0D);
    send(8'h0D);
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midclr_busy: in_ready=%b at clear column 30, required 0", in_ready);
    end
    reset = 1'b1;
    step();
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0 || top_row !== 5'd0 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midclr_reset: cur=(%0d,%0d) top=%0d wr_en=%b rdy=%b, required all 0",
               cursor_row, cursor_col, top_row, wr_en, in_ready);
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_print_bs();
    test_wrap();
    test_scroll();
    test_hold_in_clear();
    test_discard();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
